// File: rtl/calc_display_pkg.sv
`default_nettype none
// ============================================================================
// calc_display_pkg: shared state encoding and default sizes for the
// calculator display sequencer.            Rev 1.0
// ============================================================================
package calc_display_pkg;

  localparam int         STATE_W = 2;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PENDING = 2'd1;
  localparam logic [1:0] COMMIT  = 2'd2;

  localparam logic [9:0] V_BLANK_START_DEF = 10'd480;
  localparam logic [7:0] BLINK_FRAMES_DEF  = 8'd30;
  localparam int         DATA_W_DEF        = 16;

endpackage
`default_nettype wire

// File: rtl/calc_display_sequencer_if.sv
`default_nettype none
// ============================================================================
// calc_display_sequencer_if: core update handshake, display-timing input and
// renderer outputs of the display sequencer.   Rev 1.0
// ============================================================================
interface calc_display_sequencer_if
  import calc_display_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic [9:0]        vCount;
  logic              upd_valid;
  logic              upd_ready;
  logic [DATA_W-1:0] A_in;
  logic [DATA_W-1:0] B_in;
  logic [DATA_W-1:0] C_in;
  logic              flag_in;
  logic [DATA_W-1:0] A_disp;
  logic [DATA_W-1:0] B_disp;
  logic [DATA_W-1:0] C_disp;
  logic              flag_disp;
  logic              upd_done;
  logic              frame_tick;

  modport master (
    output vCount, upd_valid, A_in, B_in, C_in, flag_in,
    input  upd_ready, A_disp, B_disp, C_disp, flag_disp, upd_done, frame_tick
  );

  modport slave (
    input  vCount, upd_valid, A_in, B_in, C_in, flag_in,
    output upd_ready, A_disp, B_disp, C_disp, flag_disp, upd_done, frame_tick
  );
endinterface
`default_nettype wire

// File: rtl/calc_display_sequencer_frame_edge_detect.sv
`default_nettype none
// ============================================================================
// frame_edge_detect: one-cycle frame_tick on each entry into vertical
// blanking, registered one cycle behind the vCount compare.   Rev 1.0
// ============================================================================
module frame_edge_detect
  import calc_display_pkg::*;
#(
  parameter logic [9:0] V_BLANK_START = V_BLANK_START_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] vCount_i,
  output logic       frame_tick_o
);
  logic vblank_d;
  logic vblank_q;
  logic frame_tick_d;
  logic frame_tick_q;

  assign vblank_d     = (vCount_i >= V_BLANK_START);
  assign frame_tick_d = vblank_d & ~vblank_q;

  // vblank_q resets high so the first blanking after reset is not an edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vblank_q     <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      vblank_q     <= vblank_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign frame_tick_o = frame_tick_q;
endmodule
`default_nettype wire

// File: rtl/calc_display_sequencer.sv
`default_nettype none
// ============================================================================
// calc_display_sequencer: shadows core value sets and commits them to the
// renderer at vblank entry, with error-flag blink and done pulse.   Rev 1.0
// ============================================================================
module calc_display_sequencer
  import calc_display_pkg::*;
#(
  parameter logic [9:0] V_BLANK_START = V_BLANK_START_DEF,
  parameter logic [7:0] BLINK_FRAMES  = BLINK_FRAMES_DEF,
  parameter int         DATA_W        = DATA_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  calc_display_sequencer_if.slave bus
);
  logic [STATE_W-1:0] state_q, state_d;
  logic               frame_tick, handshake, commit;
  logic               upd_ready, upd_done;
  logic [DATA_W-1:0]  a_sh_q, b_sh_q, c_sh_q;
  logic [DATA_W-1:0]  a_sh_d, b_sh_d, c_sh_d;
  logic               flag_sh_q, flag_sh_d;
  logic [DATA_W-1:0]  a_disp_q, b_disp_q, c_disp_q;
  logic               flag_q, flag_d;
  logic [7:0]         blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;

  frame_edge_detect #(
    .V_BLANK_START (V_BLANK_START)
  ) u_frame_edge (
    .clk          (clk),
    .reset_n      (reset_n),
    .vCount_i     (bus.vCount),
    .frame_tick_o (frame_tick)
  );

  assign handshake = bus.upd_valid & upd_ready;
  assign commit    = (state_q == PENDING) & frame_tick;

  // Display loads from the _d side so a handshake coincident with the commit wins.
  assign a_sh_d    = handshake ? bus.A_in    : a_sh_q;
  assign b_sh_d    = handshake ? bus.B_in    : b_sh_q;
  assign c_sh_d    = handshake ? bus.C_in    : c_sh_q;
  assign flag_sh_d = handshake ? bus.flag_in : flag_sh_q;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (handshake) state_d = PENDING;
      PENDING: if (frame_tick) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    upd_ready = 1'b0;
    upd_done  = 1'b0;
    case (state_q)
      IDLE, PENDING: upd_ready = reset_n;
      COMMIT:        upd_done  = 1'b1;
      default:       upd_ready = 1'b0;
    endcase
  end

  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    flag_d        = flag_q;
    if (!flag_q) begin
      blink_cnt_d   = 8'd0;
      blink_phase_d = 1'b1;
    end else if (frame_tick) begin
      if (blink_cnt_q == BLINK_FRAMES - 8'd1) begin
        blink_cnt_d   = 8'd0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q + 8'd1;
      end
    end
    if (commit) begin
      flag_d = flag_sh_d;
      if (!flag_sh_d || !flag_q) begin
        blink_cnt_d   = 8'd0;
        blink_phase_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_sh_q        <= '0;
      b_sh_q        <= '0;
      c_sh_q        <= '0;
      flag_sh_q     <= 1'b0;
      a_disp_q      <= '0;
      b_disp_q      <= '0;
      c_disp_q      <= '0;
      flag_q        <= 1'b0;
      blink_cnt_q   <= 8'd0;
      blink_phase_q <= 1'b1;
    end else begin
      a_sh_q        <= a_sh_d;
      b_sh_q        <= b_sh_d;
      c_sh_q        <= c_sh_d;
      flag_sh_q     <= flag_sh_d;
      flag_q        <= flag_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      if (commit) begin
        a_disp_q <= a_sh_d;
        b_disp_q <= b_sh_d;
        c_disp_q <= c_sh_d;
      end
    end
  end

  assign bus.upd_ready  = upd_ready;
  assign bus.upd_done   = upd_done;
  assign bus.frame_tick = frame_tick;
  assign bus.A_disp     = a_disp_q;
  assign bus.B_disp     = b_disp_q;
  assign bus.C_disp     = c_disp_q;
  assign bus.flag_disp  = flag_q & (blink_phase_q | (BLINK_FRAMES == 8'd0));
endmodule
`default_nettype wire
